// File: rtl/instr_stream_tx.sv
// instr_stream_tx: byte-serial transmitter for the instruction-memory load stream.
// The host fills a 32-bit word buffer and pulses start_i. The block then emits
// SOF (0xFE), the buffered words MSB-first, and EOF (0xFF) back-to-back.
// Optional build macro: INSTR_TX_FF_GUARD_EN. When it is defined, data bytes equal
// to 0xFF are replaced by 0x00 and the sticky flag ff_err_o is raised.
module instr_stream_tx #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  output logic [7:0]    instr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          ff_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] SOF_BYTE  = 8'hFE;
  localparam logic [7:0] EOF_BYTE  = 8'hFF;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  state_t        state_r, state_s;
  logic [AW:0]   len_r, len_s;
  logic [AW-1:0] word_r, word_s;
  logic [1:0]    byte_r, byte_s;
  logic [7:0]    instr_r, instr_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          accept_start_s;
  logic          accept_wr_s;
  logic [AW:0]   len_clamp_s;
  logic [31:0]   rd_word_s;
  logic [7:0]    data_byte_s;
  logic [31:0]   mem_r [DEPTH];

`ifdef INSTR_TX_FF_GUARD_EN
  logic          ff_hit_s;
  logic          ff_err_r;
`endif

  // Byte lane select: index 0 is the most significant byte of the word.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Start and buffer writes are only honoured while no stream is in flight.
  always_comb begin
    accept_start_s = 1'b0;
    accept_wr_s    = 1'b0;
    len_clamp_s    = len_i;
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      accept_start_s = start_i;
      accept_wr_s    = wr_en_i;
    end else begin
      accept_start_s = 1'b0;
      accept_wr_s    = 1'b0;
    end
    if (len_i > (AW+1)'(DEPTH)) begin
      len_clamp_s = (AW+1)'(DEPTH);
    end else begin
      len_clamp_s = len_i;
    end
  end

  // Next-state and byte/word counter update; counters point at the byte on instr_o.
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    word_s  = word_r;
    byte_s  = byte_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_start_s) begin
          state_s = ST_SOF;
          len_s   = len_clamp_s;
          word_s  = {AW{1'b0}};
          byte_s  = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SOF: begin
        if (len_r == {(AW+1){1'b0}}) begin
          state_s = ST_EOF;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DATA: begin
        if ((byte_r == 2'd3) && (word_r == AW'(len_r - (AW+1)'(1'b1)))) begin
          state_s = ST_EOF;
        end else if (byte_r == 2'd3) begin
          byte_s = 2'd0;
          word_s = word_r + AW'(1'b1);
        end else begin
          byte_s = byte_r + 2'd1;
        end
      end
      ST_EOF: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Combinational buffer read of the byte that will be registered next.
  always_comb begin
    rd_word_s   = mem_r[word_s];
    data_byte_s = pick_byte(rd_word_s, byte_s);
  end

  // Output values for the upcoming cycle, decoded from the next state.
  always_comb begin
    instr_s  = IDLE_BYTE;
    busy_s   = 1'b0;
    done_s   = 1'b0;
`ifdef INSTR_TX_FF_GUARD_EN
    ff_hit_s = 1'b0;
`endif
    case (state_s)
      ST_SOF: begin
        instr_s = SOF_BYTE;
        busy_s  = 1'b1;
      end
      ST_DATA: begin
        busy_s = 1'b1;
`ifdef INSTR_TX_FF_GUARD_EN
        // A data 0xFF would terminate the receiver's load early.
        if (data_byte_s == EOF_BYTE) begin
          instr_s  = IDLE_BYTE;
          ff_hit_s = 1'b1;
        end else begin
          instr_s  = data_byte_s;
        end
`else
        instr_s = data_byte_s;
`endif
      end
      ST_EOF: begin
        instr_s = EOF_BYTE;
        busy_s  = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        instr_s = IDLE_BYTE;
      end
    endcase
  end

  // FSM, counters and registered stream outputs; reset aborts any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      len_r   <= {(AW+1){1'b0}};
      word_r  <= {AW{1'b0}};
      byte_r  <= 2'd0;
      instr_r <= IDLE_BYTE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      len_r   <= len_s;
      word_r  <= word_s;
      byte_r  <= byte_s;
      instr_r <= instr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Word buffer; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept_wr_s) begin
      mem_r[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef INSTR_TX_FF_GUARD_EN
  // Sticky replaced-0xFF flag, cleared when a new transfer is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_err_r <= 1'b0;
    end else if (accept_start_s) begin
      ff_err_r <= 1'b0;
    end else if (ff_hit_s) begin
      ff_err_r <= 1'b1;
    end else begin
      ff_err_r <= ff_err_r;
    end
  end

  assign ff_err_o = ff_err_r;
`else
  assign ff_err_o = 1'b0;
`endif

  assign instr_o = instr_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;

endmodule

// File: tb/tb_instr_stream_tx.sv
// Directed testbench for instr_stream_tx. Outputs are sampled 1 time unit after
// each rising clock edge; inputs change at the same point.
module tb_instr_stream_tx;

  logic        clk;
  logic        reset;
  logic        wr_en_i;
  logic [5:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        start_i;
  logic [6:0]  len_i;
  logic [7:0]  instr_o;
  logic        busy_o;
  logic        done_o;
  logic        ff_err_o;

  int          checks;
  int          failures;
  logic [31:0] model [64];

  instr_stream_tx dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .start_i   (start_i),
    .len_i     (len_i),
    .instr_o   (instr_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ff_err_o  (ff_err_o)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected byte on the wire for a data byte.
  function automatic logic [7:0] wire_byte(input logic [7:0] b);
`ifdef INSTR_TX_FF_GUARD_EN
    if (b == 8'hFF) return 8'h00;
`endif
    return b;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    logic [31:0] sh;
    sh = w >> (8 * (3 - k));
    return sh[7:0];
  endfunction

  function automatic logic [31:0] pattern(input int i);
    logic [7:0] iv;
    iv = 8'(i);
    return {iv, 8'h5A, 8'h3C, iv ^ 8'hA5};
  endfunction

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_data_i = data;
    tick();
    wr_en_i   = 1'b0;
    model[addr] = data;
  endtask

  // Start a transfer and check every byte, busy length and the done pulse.
  task automatic run_stream(input logic [6:0] len_in, input int n);
    int busy_cnt;
    start_i = 1'b1;
    len_i   = len_in;
    tick();
    start_i = 1'b0;
    wr_en_i = 1'b0;
    len_i   = 7'd0;
    chk("sof_byte", {24'd0, instr_o}, 32'h0000_00FE);
    busy_cnt = busy_o ? 1 : 0;
    for (int k = 0; k < 4 * n; k++) begin
      tick();
      chk("data_byte", {24'd0, instr_o}, {24'd0, wire_byte(byte_of(model[k / 4], k % 4))});
      if (busy_o) busy_cnt++;
    end
    tick();
    chk("eof_byte", {24'd0, instr_o}, 32'h0000_00FF);
    if (busy_o) busy_cnt++;
    tick();
    chk("done_pulse", {31'd0, done_o}, 32'd1);
    chk("busy_after", {31'd0, busy_o}, 32'd0);
    chk("idle_byte", {24'd0, instr_o}, 32'd0);
    chk("busy_cycles", 32'(busy_cnt), 32'(2 + 4 * n));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    wr_en_i   = 1'b0;
    wr_addr_i = 6'd0;
    wr_data_i = 32'd0;
    start_i   = 1'b0;
    len_i     = 7'd0;
    #1 reset = 1'b1;
    tick();
    tick();
    // Reset state.
    chk("rst_instr", {24'd0, instr_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_fferr", {31'd0, ff_err_o}, 32'd0);
    reset = 1'b0;
    tick();

    // 1. single word: FE,00,50,00,93,FF then done.
    wr(6'd0, 32'h0050_0093);
    chk("idle_pre", {24'd0, instr_o}, 32'd0);
    run_stream(7'd1, 1);
    tick();
    chk("done_one_cycle", {31'd0, done_o}, 32'd0);

    // 1b. write and start together: the new word is sent.
    wr_en_i   = 1'b1;
    wr_addr_i = 6'd0;
    wr_data_i = 32'h1234_5678;
    model[0]  = 32'h1234_5678;
    run_stream(7'd1, 1);

    // 2. zero length: FE, FF, busy exactly 2 cycles.
    run_stream(7'd0, 0);

    // 3. full buffer, then a clamped over-length request.
    for (int i = 0; i < 64; i++) wr(6'(i), pattern(i));
    run_stream(7'd64, 64);
    run_stream(7'd100, 64);

    // 4. start and write during a transfer are dropped.
    start_i = 1'b1;
    len_i   = 7'd2;
    tick();
    start_i = 1'b0;
    chk("t4_sof", {24'd0, instr_o}, 32'h0000_00FE);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t4_data", {24'd0, instr_o}, {24'd0, wire_byte(byte_of(model[k / 4], k % 4))});
      if (k == 2) begin
        start_i   = 1'b1;
        len_i     = 7'd5;
        wr_en_i   = 1'b1;
        wr_addr_i = 6'd1;
        wr_data_i = 32'hDEAD_BEEF;
      end else begin
        start_i = 1'b0;
        wr_en_i = 1'b0;
      end
    end
    tick();
    chk("t4_eof", {24'd0, instr_o}, 32'h0000_00FF);
    tick();
    chk("t4_done", {31'd0, done_o}, 32'd1);
    tick();
    chk("t4_no_queue", {31'd0, busy_o}, 32'd0);
    run_stream(7'd2, 2);

    // 5. reset in the middle of data byte 5.
    start_i = 1'b1;
    len_i   = 7'd2;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t5_byte5", {24'd0, instr_o}, {24'd0, wire_byte(byte_of(model[1], 1))});
    reset = 1'b1;
    #1;
    chk("t5_rst_instr", {24'd0, instr_o}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy_o}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_no_eof", {24'd0, instr_o}, 32'd0);
      chk("t5_idle_busy", {31'd0, busy_o}, 32'd0);
    end

    // 6. 0xFF data bytes.
    wr(6'd0, 32'hFF00_00FF);
    start_i = 1'b1;
    len_i   = 7'd1;
    tick();
    start_i = 1'b0;
    chk("t6_sof", {24'd0, instr_o}, 32'h0000_00FE);
    chk("t6_fferr_pre", {31'd0, ff_err_o}, 32'd0);
    tick();
`ifdef INSTR_TX_FF_GUARD_EN
    chk("t6_b0", {24'd0, instr_o}, 32'h0000_0000);
    chk("t6_fferr_set", {31'd0, ff_err_o}, 32'd1);
`else
    chk("t6_b0", {24'd0, instr_o}, 32'h0000_00FF);
    chk("t6_fferr_set", {31'd0, ff_err_o}, 32'd0);
`endif
    tick();
    chk("t6_b1", {24'd0, instr_o}, 32'h0000_0000);
    tick();
    chk("t6_b2", {24'd0, instr_o}, 32'h0000_0000);
    tick();
`ifdef INSTR_TX_FF_GUARD_EN
    chk("t6_b3", {24'd0, instr_o}, 32'h0000_0000);
`else
    chk("t6_b3", {24'd0, instr_o}, 32'h0000_00FF);
`endif
    tick();
    chk("t6_eof", {24'd0, instr_o}, 32'h0000_00FF);
    tick();
    chk("t6_done", {31'd0, done_o}, 32'd1);
`ifdef INSTR_TX_FF_GUARD_EN
    chk("t6_sticky", {31'd0, ff_err_o}, 32'd1);
`else
    chk("t6_sticky", {31'd0, ff_err_o}, 32'd0);
`endif
    run_stream(7'd0, 0);
    chk("t6_cleared", {31'd0, ff_err_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
